// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between video, CPU and loader with a registered req/ack handshake.
// Video has priority under a starvation guard; CPU and loader alternate round-robin.
module mem_arbiter #(
    parameter int AW      = 14,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1,
    parameter int MAX_VID = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q,
    output logic          busy
);
    localparam int SW = $clog2(MAX_VID + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t        state, state_nx;
    logic [2:0]    grant;
    logic          rr;
    logic [SW-1:0] vid_streak;
    logic [1:0]    wcnt;
    logic          other, any, vid_win, cpu_win, ldr_win, last_wait;
    always_comb begin
        other     = cpu_req | ldr_req;
        any       = vid_req | other;
        vid_win   = vid_req && !(vid_streak == SW'(MAX_VID) && other);
        cpu_win   = !vid_win && cpu_req && (!ldr_req || !rr);
        ldr_win   = !vid_win && ldr_req && !cpu_win;
        last_wait = wcnt == 2'(RD_LAT - 1);
        busy      = state != IDLE;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = any ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = last_wait ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // grant is one-hot {ldr, cpu, vid} for the access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            rr         <= 1'b0;
            vid_streak <= '0;
            wcnt       <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            rdata      <= '0;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            if (state == IDLE) begin
                wcnt       <= '0;
                vid_streak <= (vid_win && other) ?
                              (vid_streak == SW'(MAX_VID) ? vid_streak : vid_streak + SW'(1)) : '0;
                if (any) begin
                    grant     <= {ldr_win, cpu_win, vid_win};
                    mem_addr  <= vid_win ? vid_addr : cpu_win ? cpu_addr : ldr_addr;
                    mem_wdata <= cpu_win ? cpu_wdata : ldr_win ? ldr_wdata : '0;
                    mem_we    <= cpu_win ? cpu_we : ldr_win & ldr_we;
                end
                if (cpu_win) rr <= 1'b1;
                if (ldr_win) rr <= 1'b0;
            end
            if (state == WAIT) begin
                wcnt <= wcnt + 2'd1;
                if (last_wait) begin
                    rdata                       <= mem_q;
                    {ldr_ack, cpu_ack, vid_ack} <= grant;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with behavioural RAMs and an ack scoreboard for mem_arbiter.
module tb_mem_arbiter;
    localparam logic [2:0] V = 3'b001, C = 3'b010, L = 3'b100;
    typedef struct {
        logic [2:0] port;
        logic       rd;
        logic [7:0] d;
    } exp_t;
    logic        clk = 0, rst = 1;
    logic        vid_req = 1, cpu_req = 1, cpu_we = 1, ldr_req = 1, ldr_we = 1;
    logic [13:0] vid_addr = 0, cpu_addr = 0, ldr_addr = 0;
    logic [7:0]  cpu_wdata = 0, ldr_wdata = 0;
    logic        vid_ack, cpu_ack, ldr_ack, mem_we, busy;
    logic [7:0]  rdata, mem_wdata, mem_q;
    logic [13:0] mem_addr;
    logic        l3_req = 0, l3_ack, v3_ack, c3_ack, m3_we, busy3;
    logic [13:0] l3_addr = 0, m3_addr;
    logic [7:0]  rdata3, m3_wdata, q3;
    logic [7:0]  mem0 [0:16383];
    logic [7:0]  mem3 [0:16383];
    logic [7:0]  p3 [0:2];
    int          cyc = 0, checks = 0, errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [2:0]  mon_a;
    logic        prev_we = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    mem_arbiter u0 (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q), .busy(busy)
    );
    mem_arbiter #(.RD_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .vid_req(1'b0), .vid_addr(14'd0), .vid_ack(v3_ack),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(14'd0), .cpu_wdata(8'd0), .cpu_ack(c3_ack),
        .ldr_req(l3_req), .ldr_we(1'b0), .ldr_addr(l3_addr), .ldr_wdata(8'd0), .ldr_ack(l3_ack),
        .rdata(rdata3), .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_we(m3_we), .mem_q(q3), .busy(busy3)
    );
    function automatic logic [7:0] f(input logic [13:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction
    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem0[i] = f(14'(i));
            mem3[i] = f(14'(i));
        end
        mem3[14'h3FFF] = 8'h5C;
    end
    always @(posedge clk) begin
        if (mem_we) mem0[mem_addr] <= mem_wdata;
        mem_q <= mem0[mem_addr];
        p3[0] <= mem3[m3_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q3 = p3[2];
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic void push(input logic [2:0] p, input logic rd, input logic [7:0] d);
        exp_t e;
        e.port = p;
        e.rd   = rd;
        e.d    = d;
        sb.push_back(e);
    endfunction
    task automatic wait_ack(input logic [2:0] mask, output logic [2:0] got, output int at);
        got = 0;
        at  = -1;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (({ldr_ack, cpu_ack, vid_ack} & mask) != 0) begin
                got = {ldr_ack, cpu_ack, vid_ack};
                at  = cyc;
            end
        end
    endtask
    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) if (cyc > 0) begin
        mon_a = {ldr_ack, cpu_ack, vid_ack};
        if (mon_a != 0) begin
            if (sb.size() == 0) check("unexpected_ack", {29'd0, mon_a}, 0);
            else begin
                mon_e = sb.pop_front();
                check("ack_port", {29'd0, mon_a}, {29'd0, mon_e.port});
                if (mon_e.rd) check("ack_rdata", {24'd0, rdata}, {24'd0, mon_e.d});
            end
        end
        if (mem_we) check("we_gap", {31'd0, prev_we}, 0);
        prev_we = mem_we;
    end
    initial begin
        logic [2:0] got;
        int t, at, prev;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ctl", {27'd0, vid_ack, cpu_ack, ldr_ack, mem_we, busy}, 0);
            check("rst_addr", {18'd0, mem_addr}, 0);
            check("rst_data", {16'd0, rdata, mem_wdata}, 0);
            check("rst_u3", {29'd0, l3_ack, m3_we, busy3}, 0);
        end
        rst = 0; vid_req = 0; cpu_req = 0; ldr_req = 0; cpu_we = 0; ldr_we = 0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);
        // CPU and loader both pending: alternate starting with CPU
        cpu_addr = 14'h0155; ldr_addr = 14'h0266; cpu_req = 1; ldr_req = 1;
        for (int i = 0; i < 6; i++) push(i % 2 ? L : C, 1, i % 2 ? f(14'h0266) : f(14'h0155));
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            wait_ack(C | L, got, at);
            check("rr_port", {29'd0, got}, {29'd0, i % 2 ? L : C});
            if (i > 0) check("rr_spacing", at - prev, 4);
            prev = at;
        end
        after_edge();
        cpu_req = 0; ldr_req = 0;
        // CPU write then back-to-back read of the same location
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'h1234; cpu_wdata = 8'hA5; t = cyc;
        push(C, 0, 0);
        @(negedge clk);
        check("wr_we", {31'd0, mem_we}, 1);
        check("wr_addr", {18'd0, mem_addr}, 32'h1234);
        check("wr_wdata", {24'd0, mem_wdata}, 32'hA5);
        check("wr_busy", {31'd0, busy}, 1);
        @(negedge clk);
        check("wr_we_low", {31'd0, mem_we}, 0);
        check("wr_addr_hold", {18'd0, mem_addr}, 32'h1234);
        wait_ack(C, got, at);
        check("wr_ack_lat", at, t + 3);
        push(C, 1, 8'hA5);
        after_edge();
        cpu_we = 0;
        wait_ack(C, got, at);
        check("rd_ack_lat", at, t + 7);
        check("rd_data", {24'd0, rdata}, 32'hA5);
        after_edge();
        cpu_req = 0;
        // video plus CPU pending: 4 video grants then one CPU grant
        @(negedge clk);
        vid_addr = 14'h0311; cpu_addr = 14'h0422; vid_req = 1; cpu_req = 1;
        for (int i = 0; i < 14; i++) push(i % 5 == 4 ? C : V, 1, i % 5 == 4 ? f(14'h0422) : f(14'h0311));
        for (int i = 0; i < 14; i++) begin
            wait_ack(V | C, got, at);
            check("starve_port", {29'd0, got}, {29'd0, i % 5 == 4 ? C : V});
        end
        after_edge();
        vid_req = 0; cpu_req = 0;
        // reset while the read is in WAIT: abandoned, then re-served cleanly
        @(negedge clk);
        cpu_addr = 14'h0577; cpu_req = 1; t = cyc;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 1);
        rst = 1;
        @(negedge clk);
        check("mid_noack", {29'd0, ldr_ack, cpu_ack, vid_ack}, 0);
        check("mid_idle", {31'd0, busy}, 0);
        rst = 0;
        @(negedge clk);
        push(C, 1, f(14'h0577));
        wait_ack(C, got, at);
        check("mid_relat", at, t + 6);
        after_edge();
        cpu_req = 0;
        // RD_LAT = 3 instance: loader read at the top address
        @(negedge clk);
        l3_req = 1; l3_addr = 14'h3FFF; t = cyc;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("l3_addr", {18'd0, m3_addr}, 32'h3FFF);
            check("l3_noack", {31'd0, l3_ack}, 0);
        end
        at = -1;
        for (int i = 0; i < 20 && at < 0; i++) begin
            @(negedge clk);
            if (l3_ack) at = cyc;
        end
        check("l3_ack_lat", at, t + 5);
        check("l3_rdata", {24'd0, rdata3}, 32'h5C);
        after_edge();
        l3_req = 0;
        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
